// File: rtl/vga_sync.sv
// VGA timing generator: divides clk by 4 into a pixel strobe, scans x/y
// over the full raster, and produces registered active-low syncs.
//
// Ports:
//   clk        in   system clock, all state updates on its rising edge
//   reset      in   synchronous, active-high; restarts at x=0, y=0
//   p_tick     out  one-clk pixel strobe, every 4th clk
//   x          out  pixel column counter, 0..H_TOTAL-1
//   y          out  line counter, 0..V_TOTAL-1
//   video_on   out  high inside the visible area
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   frame_tick out  one-clk pulse on the last pixel of each frame
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [1:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic tick;
  logic x_end;
  logic y_end;

  assign tick  = (div_q == 2'd3);
  assign x_end = (x_q == H_LAST);
  assign y_end = (y_q == V_LAST);

  always_comb begin
    div_d = div_q + 2'd1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_end) begin
        x_d = '0;
        if (y_end) y_d = '0;
        else       y_d = y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Syncs decode the next counter values so the registered
    // outputs change on the same edge as x and y.
    hsync_d = ~((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d = ~((y_d >= VS_FIRST) && (y_d <= VS_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign p_tick     = tick;
  assign x          = x_q;
  assign y          = y_q;
  assign video_on   = (x_q < H_VIS) && (y_q < V_VIS);
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = tick && x_end && y_end;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: one default-timing instance and one
// shrunken-raster instance so full frames fit in a short run.
module tb_vga_sync;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  logic       d_pt, d_vo, d_hs, d_vs, d_ft;
  logic [9:0] d_x, d_y;
  logic       s_pt, s_vo, s_hs, s_vs, s_ft;
  logic [9:0] s_x, s_y;

  vga_sync u_dut (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (d_pt),
    .x         (d_x),
    .y         (d_y),
    .video_on  (d_vo),
    .hsync     (d_hs),
    .vsync     (d_vs),
    .frame_tick(d_ft)
  );

  // 15 x 10 raster: hsync low x in [10,12], vsync low y in [7,8]
  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (s_pt),
    .x         (s_x),
    .y         (s_y),
    .video_on  (s_vo),
    .hsync     (s_hs),
    .vsync     (s_vs),
    .frame_tick(s_ft)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int d_mism, s_mism;
  int max_dx, max_dy, max_sx, max_sy;
  int dbl_pt;
  int s_ft_cnt, s_ft_f0, s_vis_f0, s_vsl_f0;
  bit prev_pt;
  bit found;

  initial begin
    d_mism = 0; s_mism = 0;
    max_dx = 0; max_dy = 0; max_sx = 0; max_sy = 0;
    dbl_pt = 0; prev_pt = 0;
    s_ft_cnt = 0; s_ft_f0 = 0; s_vis_f0 = 0; s_vsl_f0 = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x", 32'(d_x), 0);
    chk("rst_y", 32'(d_y), 0);
    chk("rst_hs", 32'(d_hs), 1);
    chk("rst_vs", 32'(d_vs), 1);
    chk("rst_pt", 32'(d_pt), 0);
    chk("rst_ft", 32'(d_ft), 0);
    chk("rst_vo", 32'(d_vo), 1);
    chk("rst_s_vs", 32'(s_vs), 1);

    reset = 1'b0;
    for (int c = 0; c < 3210; c++) begin
      int ex, ey, sx, sy;
      bit eh, ep, ev, shs, svs, sv, sft;
      ex  = (c / 4) % 800;
      ey  = (c / 3200) % 525;
      ep  = (c % 4) == 3;
      eh  = !(ex >= 656 && ex <= 751);
      ev  = (ex < 640) && (ey < 480);
      sx  = (c / 4) % 15;
      sy  = (c / 60) % 10;
      shs = !(sx >= 10 && sx <= 12);
      svs = !(sy >= 7 && sy <= 8);
      sv  = (sx < 8) && (sy < 6);
      sft = (c % 600) == 599;

      if (d_x !== 10'(ex) || d_y !== 10'(ey) || d_pt !== ep ||
          d_hs !== eh || d_vs !== 1'b1 || d_vo !== ev ||
          d_ft !== 1'b0)
        d_mism++;
      if (s_x !== 10'(sx) || s_y !== 10'(sy) || s_pt !== ep ||
          s_hs !== shs || s_vs !== svs || s_vo !== sv ||
          s_ft !== sft)
        s_mism++;

      if (int'(d_x) > max_dx) max_dx = int'(d_x);
      if (int'(d_y) > max_dy) max_dy = int'(d_y);
      if (int'(s_x) > max_sx) max_sx = int'(s_x);
      if (int'(s_y) > max_sy) max_sy = int'(s_y);
      if (prev_pt && d_pt) dbl_pt++;
      prev_pt = d_pt;
      if (s_ft) s_ft_cnt++;
      if (c < 600) begin
        if (s_ft) s_ft_f0++;
        if (s_vo && s_pt) s_vis_f0++;
        if (!s_vs) s_vsl_f0++;
      end

      case (c)
        0: begin
          chk("c0_pt", 32'(d_pt), 0);
          chk("c0_x", 32'(d_x), 0);
        end
        3: begin
          chk("c3_pt", 32'(d_pt), 1);
          chk("c3_x", 32'(d_x), 0);
        end
        4: begin
          chk("c4_x", 32'(d_x), 1);
          chk("c4_pt", 32'(d_pt), 0);
        end
        7: chk("c7_pt", 32'(d_pt), 1);
        8: chk("c8_x", 32'(d_x), 2);
        2559: chk("vo_x639", 32'(d_vo), 1);
        2560: chk("vo_x640", 32'(d_vo), 0);
        2623: chk("hs_x655", 32'(d_hs), 1);
        2624: begin
          chk("hs_x656_x", 32'(d_x), 656);
          chk("hs_x656", 32'(d_hs), 0);
        end
        3007: chk("hs_x751", 32'(d_hs), 0);
        3008: begin
          chk("hs_x752_x", 32'(d_x), 752);
          chk("hs_x752", 32'(d_hs), 1);
        end
        3199: begin
          chk("c3199_x", 32'(d_x), 799);
          chk("c3199_y", 32'(d_y), 0);
          chk("c3199_pt", 32'(d_pt), 1);
        end
        3200: begin
          chk("wrap_x", 32'(d_x), 0);
          chk("wrap_y", 32'(d_y), 1);
        end
        599: begin
          chk("s_ft599", 32'(s_ft), 1);
          chk("s_x599", 32'(s_x), 14);
          chk("s_y599", 32'(s_y), 9);
        end
        600: begin
          chk("s_x600", 32'(s_x), 0);
          chk("s_y600", 32'(s_y), 0);
          chk("s_ft600", 32'(s_ft), 0);
        end
        default: ;
      endcase
      step();
    end

    chk("d_trace", 32'(d_mism), 0);
    chk("s_trace", 32'(s_mism), 0);
    chk("d_xmax", 32'(max_dx), 799);
    chk("d_ymax", 32'(max_dy), 1);
    chk("s_xmax", 32'(max_sx), 14);
    chk("s_ymax", 32'(max_sy), 9);
    chk("pt_double", 32'(dbl_pt), 0);
    chk("s_ft_f0", 32'(s_ft_f0), 1);
    chk("s_ft_total", 32'(s_ft_cnt), 5);
    chk("s_vis_f0", 32'(s_vis_f0), 48);
    chk("s_vsl_f0", 32'(s_vsl_f0), 120);

    // Find a spot with both syncs of the small raster asserted.
    found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      if (s_x == 10'd11 && s_y == 10'd7 && s_pt == 1'b0) found = 1;
      else step();
    end
    chk("hunt", 32'(found), 1);
    chk("mid_s_hs", 32'(s_hs), 0);
    chk("mid_s_vs", 32'(s_vs), 0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_s_x", 32'(s_x), 0);
    chk("mr_s_y", 32'(s_y), 0);
    chk("mr_s_hs", 32'(s_hs), 1);
    chk("mr_s_vs", 32'(s_vs), 1);
    chk("mr_s_pt", 32'(s_pt), 0);
    chk("mr_d_x", 32'(d_x), 0);
    chk("mr_d_y", 32'(d_y), 0);
    step();
    chk("mr_c1_pt", 32'(s_pt), 0);
    step();
    chk("mr_c2_pt", 32'(s_pt), 0);
    step();
    chk("mr_c3_pt", 32'(s_pt), 1);
    chk("mr_c3_x", 32'(s_x), 0);
    step();
    chk("mr_c4_x", 32'(s_x), 1);
    chk("mr_c4_dx", 32'(d_x), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL expose parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 The block SHALL expose parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL expose parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 The block SHALL expose parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL expose parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 The block SHALL expose parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL expose parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 The block SHALL expose parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL have port clk, input, 1 bit: 100 MHz system clock; the design has one clock, and all state updates on its rising edge.
REQ-010 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-011 The block SHALL have port p_tick, output, 1 bit: one-clk pixel strobe at 25 MHz.
REQ-012 The block SHALL have port x, output, 10 bits: current pixel column counter.
REQ-013 The block SHALL have port y, output, 10 bits: current line counter.
REQ-014 The block SHALL have port video_on, output, 1 bit: high when the current position is in the visible area.
REQ-015 The block SHALL have port hsync, output, 1 bit: horizontal sync, active low.
REQ-016 The block SHALL have port vsync, output, 1 bit: vertical sync, active low.
REQ-017 The block SHALL have port frame_tick, output, 1 bit: one-clk pulse on the last pixel of each frame.

Function
REQ-018 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-019 A 2-bit divider SHALL increment every clk and wrap 3->0; p_tick SHALL be high exactly when the divider equals 3.
REQ-020 x SHALL increment on each clk edge where p_tick=1; x SHALL otherwise hold for all 4 clks of a pixel.
REQ-021 At x=H_TOTAL-1 with p_tick=1, x SHALL wrap to 0 and y SHALL increment on the same edge.
REQ-022 At x=H_TOTAL-1, y=V_TOTAL-1 with p_tick=1, both x and y SHALL wrap to 0 on the same edge.
REQ-023 x SHALL never exceed 799 and y SHALL never exceed 524.
REQ-024 video_on SHALL equal (x<H_DISPLAY)&&(y<V_DISPLAY), decoded from the registered counters with no extra latency.
REQ-025 hsync SHALL be registered and low exactly while x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751], changing on the same edge as x.
REQ-026 vsync SHALL be registered and low exactly while y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491], changing on the same edge as y.
REQ-027 frame_tick SHALL be high for exactly one clk: the cycle where x=799, y=524 and p_tick=1.
REQ-028 Line period SHALL be 3200 clks; frame period SHALL be 1,680,000 clks.

Reset
REQ-029 While reset=1 at a clk edge: divider=0, x=0, y=0, hsync=1, vsync=1; p_tick=0 and frame_tick=0 on the following cycle; video_on=1.
REQ-030 Reset asserted mid-line or mid-frame SHALL take effect on the next edge and restart timing from x=0, y=0, divider=0.
REQ-031 After reset is released, the first p_tick SHALL occur on the 4th clk (divider=3), and x SHALL read 1 after that edge.

Verification
REQ-032 Release reset, count clks -> p_tick high on cycles 3, 7, 11, ...; x=1 after cycle 3, x=2 after cycle 7.
REQ-033 Run one line -> hsync falls when x becomes 656, rises when x becomes 752; x wraps 799->0 with y 0->1 at clk 3199.
REQ-034 Run one frame -> vsync low for exactly 2 lines (y=490,491, 6400 clks); frame_tick single pulse at clk 1,679,999; x=y=0 on the next pixel.
REQ-035 Sweep a full frame -> video_on high for exactly 307,200 pixel ticks and low at x=640 or y=480.
REQ-036 Assert reset for 1 clk at x=700, y=300 -> next cycle x=0, y=0, hsync=1, vsync=1, divider restarted.
REQ-037 Check every cycle -> x<800, y<525; p_tick is never high on two consecutive clks.
